// File: rtl/jump_physics_pkg.sv
// Shared definitions for the jump_physics slice.
//   jump_state_e : motion phases of the jump controller
//   DEF_*        : board defaults (27 MHz clock) for step/debounce timing and offset width
//   cnt_width()  : counter width for a modulo-n counter, never below 1 bit
package jump_physics_pkg;

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    HANG   = 2'd2,
    FALL   = 2'd3
  } jump_state_e;

  localparam int unsigned DEF_OFFSET_W        = 5;
  localparam int unsigned DEF_STEP_CYCLES     = 450000;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 270000;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/jump_physics_btn_debounce.sv
// Button conditioning for jump_physics.
//   clk, rst : system clock, synchronous active-high reset
//   btn_i    : raw asynchronous button pin
//   level_o  : debounced pressed level (1 = pressed, polarity already normalised)
//   press_o  : one-cycle pulse on the debounced released->pressed transition
module btn_debounce
  import jump_physics_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);

  localparam int unsigned   CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  // Raw pin level that means "released"; the synchroniser resets to it so
  // leaving reset never looks like a press.
  localparam logic          IDLE_RAW = BTN_ACTIVE_LOW;

  logic          sync1_q, sync2_q;
  logic          synced;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= IDLE_RAW;
      sync2_q <= IDLE_RAW;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign synced = sync2_q ^ BTN_ACTIVE_LOW;

  // Count consecutive cycles the synchronised input disagrees with the
  // debounced level; a single agreeing cycle restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (synced != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = synced;
        press_d = synced;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/jump_physics.sv
// Jump controller: converts btn1 into a multi-bit vertical dino offset with
// rise / hang / fall phases and an optional mid-air double jump.
//   clk        : system clock
//   rst        : synchronous reset, active high
//   btn1       : raw asynchronous push button
//   jumpOffset : current height above ground in pixels (registered)
//   airborne   : high while in RISE, HANG or FALL
//   landed     : one-cycle pulse on the FALL->GROUND transition
module jump_physics
  import jump_physics_pkg::*;
#(
  parameter int unsigned OFFSET_W        = DEF_OFFSET_W,
  parameter int unsigned MAX_HEIGHT      = 24,
  parameter int unsigned RISE_STEP       = 3,
  parameter int unsigned FALL_STEP       = 2,
  parameter int unsigned HANG_STEPS      = 4,
  parameter int unsigned STEP_CYCLES     = DEF_STEP_CYCLES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1,
  parameter bit          ALLOW_DOUBLE    = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn1,
  output logic [OFFSET_W-1:0] jumpOffset,
  output logic                airborne,
  output logic                landed
);

  localparam int unsigned   SW        = cnt_width(STEP_CYCLES);
  localparam int unsigned   HW        = cnt_width(HANG_STEPS);
  localparam int unsigned   OW1       = OFFSET_W + 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);
  localparam logic [HW-1:0] HANG_LAST = HW'(HANG_STEPS - 1);
  localparam logic [OW1-1:0]      APEX_W   = OW1'(MAX_HEIGHT);
  localparam logic [OFFSET_W-1:0] APEX     = OFFSET_W'(MAX_HEIGHT);
  localparam logic [OFFSET_W-1:0] FALL_DEC = OFFSET_W'(FALL_STEP);

  logic                btn_level, btn_press, press;
  jump_state_e         state_q, state_d;
  logic [OFFSET_W-1:0] offset_q, offset_d;
  logic [SW-1:0]       step_q, step_d;
  logic [HW-1:0]       hang_q, hang_d;
  logic                used_q, used_d;
  logic                pend_q, pend_d;
  logic                landed_q, landed_d;
  logic                tick, landing, dbl;
  logic [OW1-1:0]      rise_sum;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
  ) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (btn1),
    .level_o (btn_level),
    .press_o (btn_press)
  );

  // A press is the rising edge of the debounced level, so both agree.
  assign press    = btn_press & btn_level;
  assign tick     = (step_q == STEP_LAST);
  // One extra bit so offset + RISE_STEP cannot wrap before saturation.
  assign rise_sum = {1'b0, offset_q} + OW1'(RISE_STEP);
  assign landing  = (state_q == FALL) && tick && (offset_q <= FALL_DEC);
  assign dbl      = ALLOW_DOUBLE && press && !used_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= GROUND;
      offset_q <= '0;
      step_q   <= '0;
      hang_q   <= '0;
      used_q   <= 1'b0;
      pend_q   <= 1'b0;
      landed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      step_q   <= step_d;
      hang_q   <= hang_d;
      used_q   <= used_d;
      pend_q   <= pend_d;
      landed_q <= landed_d;
    end
  end

  // Priority while airborne: landing beats a double-jump press (the press is
  // parked in pend_q and starts a fresh jump from GROUND one cycle later),
  // and an accepted double jump beats a coincident motion tick.
  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    step_d   = tick ? '0 : step_q + SW'(1);
    hang_d   = hang_q;
    used_d   = used_q;
    pend_d   = 1'b0;
    landed_d = 1'b0;
    if (state_q == GROUND) begin
      if (press || pend_q) begin
        state_d  = RISE;
        offset_d = '0;
        used_d   = 1'b0;
        step_d   = '0;
      end
    end else if (landing) begin
      state_d  = GROUND;
      offset_d = '0;
      landed_d = 1'b1;
      pend_d   = press;
    end else if (dbl) begin
      state_d = RISE;
      used_d  = 1'b1;
      step_d  = '0;
    end else if (tick) begin
      case (state_q)
        RISE: begin
          if (rise_sum >= APEX_W) begin
            offset_d = APEX;
            hang_d   = '0;
            state_d  = (HANG_STEPS == 0) ? FALL : HANG;
          end else begin
            offset_d = rise_sum[OFFSET_W-1:0];
          end
        end
        HANG: begin
          if (hang_q == HANG_LAST) state_d = FALL;
          else                     hang_d  = hang_q + HW'(1);
        end
        FALL:    offset_d = offset_q - FALL_DEC;
        default: state_d  = GROUND;
      endcase
    end
  end

  assign jumpOffset = offset_q;
  assign airborne   = (state_q != GROUND);
  assign landed     = landed_q;

endmodule

// File: tb/tb_jump_physics.sv
// Bench for jump_physics: three instances share btn1/rst
//   a: base parameters, single jump
//   b: base parameters, double jump enabled
//   c: MAX_HEIGHT 31, RISE_STEP 7 (saturation)
// A trajectory model predicts every output each cycle; literal pins check the model.
module tb_jump_physics;

  localparam int STEP  = 4;
  localparam int DEB   = 3;
  localparam int HANG  = 4;
  localparam int FALLS = 2;

  function automatic int max_of(input int i);  return (i == 2) ? 31 : 24; endfunction
  function automatic int rise_of(input int i); return (i == 2) ? 7 : 3;   endfunction
  function automatic bit dbl_of(input int i);  return (i == 1);           endfunction

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn1 = 1'b0;
  logic [4:0] off_a, off_b, off_c;
  logic       air_a, air_b, air_c, land_a, land_b, land_c;

  always #5 clk = ~clk;

  jump_physics #(.OFFSET_W(5), .MAX_HEIGHT(24), .RISE_STEP(3), .FALL_STEP(2), .HANG_STEPS(4),
    .STEP_CYCLES(4), .DEBOUNCE_CYCLES(3), .BTN_ACTIVE_LOW(1'b1), .ALLOW_DOUBLE(1'b0))
  u_a (.clk(clk), .rst(rst), .btn1(btn1), .jumpOffset(off_a), .airborne(air_a), .landed(land_a));

  jump_physics #(.OFFSET_W(5), .MAX_HEIGHT(24), .RISE_STEP(3), .FALL_STEP(2), .HANG_STEPS(4),
    .STEP_CYCLES(4), .DEBOUNCE_CYCLES(3), .BTN_ACTIVE_LOW(1'b1), .ALLOW_DOUBLE(1'b1))
  u_b (.clk(clk), .rst(rst), .btn1(btn1), .jumpOffset(off_b), .airborne(air_b), .landed(land_b));

  jump_physics #(.OFFSET_W(5), .MAX_HEIGHT(31), .RISE_STEP(7), .FALL_STEP(2), .HANG_STEPS(4),
    .STEP_CYCLES(4), .DEBOUNCE_CYCLES(3), .BTN_ACTIVE_LOW(1'b1), .ALLOW_DOUBLE(1'b0))
  u_c (.clk(clk), .rst(rst), .btn1(btn1), .jumpOffset(off_c), .airborne(air_c), .landed(land_c));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_checks++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  int n;
  bit m_sync0, m_sync1, m_lvl, m_press;
  int m_run;
  bit act[3], used[3], pend[3];
  int s[3], o0[3], len[3];
  int traj[3][64];
  int m_off[3];
  bit m_air[3], m_land[3];
  bit model_ok = 1'b0;

  // Offsets after each motion tick of a jump starting at height start.
  task automatic build(input int i, input int start);
    int h;
    int k;
    h = start;
    k = 0;
    o0[i] = start;
    do begin
      h = h + rise_of(i);
      if (h > max_of(i)) h = max_of(i);
      traj[i][k] = h;
      k = k + 1;
    end while (h < max_of(i));
    for (int j = 0; j < HANG; j++) begin
      traj[i][k] = h;
      k = k + 1;
    end
    while (h > 0) begin
      h = (h > FALLS) ? h - FALLS : 0;
      traj[i][k] = h;
      k = k + 1;
    end
    len[i] = k;
  endtask

  always @(posedge clk) begin
    bit honour, press_now, synced;
    if (rst) begin
      n = 0; m_sync0 = 0; m_sync1 = 0; m_lvl = 0; m_run = 0; m_press = 0;
      for (int i = 0; i < 3; i++) begin
        act[i] = 0; used[i] = 0; pend[i] = 0; m_off[i] = 0; m_air[i] = 0; m_land[i] = 0;
      end
    end else begin
      n++;
      honour    = m_press;
      press_now = 0;
      synced    = m_sync1;
      if (synced != m_lvl) begin
        m_run++;
        if (m_run == DEB) begin
          m_lvl = synced; m_run = 0; press_now = synced;
        end
      end else begin
        m_run = 0;
      end
      m_sync1 = m_sync0;
      m_sync0 = (btn1 == 1'b0);
      m_press = press_now;
      for (int i = 0; i < 3; i++) begin
        m_land[i] = 0;
        if (act[i] && (n - s[i]) == len[i] * STEP) begin
          act[i] = 0; m_land[i] = 1; pend[i] = honour;
        end else if (!act[i]) begin
          if (honour || pend[i]) begin
            act[i] = 1; used[i] = 0; build(i, 0); s[i] = n;
          end
          pend[i] = 0;
        end else if (honour && dbl_of(i) && !used[i]) begin
          used[i] = 1; build(i, m_off[i]); s[i] = n;
        end
        if (!act[i])                     m_off[i] = 0;
        else if ((n - s[i]) / STEP == 0) m_off[i] = o0[i];
        else                             m_off[i] = traj[i][(n - s[i]) / STEP - 1];
        m_air[i] = act[i];
      end
    end
    model_ok = 1'b1;
  end

  // ---------------- compare + capture ----------------
  bit cap = 0;
  int cyc = 0;
  int seq_a[$];
  int last_a, at24, last_land, gap;
  int air_cnt[3], land_cnt[3], max_off[3];
  bit prev_air = 0;

  always @(negedge clk) begin
    int o[3];
    bit a[3], l[3];
    cyc++;
    if (model_ok) begin
      chk("offset_a", {27'b0, off_a}, m_off[0]);
      chk("airborne_a", {31'b0, air_a}, int'(m_air[0]));
      chk("landed_a", {31'b0, land_a}, int'(m_land[0]));
      chk("offset_b", {27'b0, off_b}, m_off[1]);
      chk("airborne_b", {31'b0, air_b}, int'(m_air[1]));
      chk("landed_b", {31'b0, land_b}, int'(m_land[1]));
      chk("offset_c", {27'b0, off_c}, m_off[2]);
      chk("airborne_c", {31'b0, air_c}, int'(m_air[2]));
      chk("landed_c", {31'b0, land_c}, int'(m_land[2]));
    end
    o[0] = int'(off_a); o[1] = int'(off_b); o[2] = int'(off_c);
    a[0] = air_a; a[1] = air_b; a[2] = air_c;
    l[0] = land_a; l[1] = land_b; l[2] = land_c;
    if (cap) begin
      for (int i = 0; i < 3; i++) begin
        if (a[i]) air_cnt[i]++;
        if (l[i]) land_cnt[i]++;
        if (o[i] > max_off[i]) max_off[i] = o[i];
      end
      if (o[0] != last_a) begin seq_a.push_back(o[0]); last_a = o[0]; end
      if (o[0] == 24) at24++;
      if (l[0]) last_land = cyc;
      if (a[0] && !prev_air && last_land >= 0 && gap < 0) gap = cyc - last_land;
    end
    prev_air = a[0];
  end

  task automatic cap_begin();
    seq_a.delete();
    last_a = 0; at24 = 0; last_land = -1; gap = -1;
    for (int i = 0; i < 3; i++) begin air_cnt[i] = 0; land_cnt[i] = 0; max_off[i] = 0; end
    cap = 1;
  endtask

  int exp_seq[20] = '{3, 6, 9, 12, 15, 18, 21, 24, 22, 20, 18, 16, 14, 12, 10, 8, 6, 4, 2, 0};

  task automatic check_seq_a(input string tag);
    chk({tag, "_len"}, seq_a.size(), 20);
    for (int k = 0; k < 20 && k < seq_a.size(); k++)
      chk($sformatf("%s_step%0d", tag, k), seq_a[k], exp_seq[k]);
  endtask

  task automatic press(input int hold);
    btn1 = 1'b0;
    repeat (hold) @(negedge clk);
    btn1 = 1'b1;
  endtask

  task automatic wait_off(input int i, input int v, input int limit, input string tag);
    int k;
    k = 0;
    while (m_off[i] != v && k < limit) begin @(negedge clk); k++; end
    if (m_off[i] != v) begin
      n_checks++; n_fail++;
      $display("FAIL %s: timeout, model offset %0d expected %0d", tag, m_off[i], v);
    end
  endtask

  task automatic wait_edge(input int target, input int limit, input string tag);
    int k;
    k = 0;
    while (n < target && k < limit) begin @(negedge clk); k++; end
    if (n != target) begin
      n_checks++; n_fail++;
      $display("FAIL %s: timeout, edge %0d expected %0d", tag, n, target);
    end
  endtask

  initial begin
    // Reset with btn1 low (pressed) for two cycles.
    btn1 = 1'b0; rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_offset", {27'b0, off_a}, 0);
    chk("rst_airborne", {31'b0, air_a}, 0);
    chk("rst_landed", {31'b0, land_a}, 0);
    btn1 = 1'b1; rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst_no_press", {31'b0, air_a}, 0);

    // Full single jump.
    cap_begin();
    press(10);
    repeat (120) @(negedge clk);
    cap = 0;
    check_seq_a("full");
    chk("full_air_cycles", air_cnt[0], 96);
    chk("full_land_pulses", land_cnt[0], 1);
    chk("full_apex_cycles", at24, 20);

    // Bounce: toggling every 2 cycles never registers.
    cap_begin();
    for (int k = 0; k < 5; k++) begin
      btn1 = 1'b0; repeat (2) @(negedge clk);
      btn1 = 1'b1; repeat (2) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    chk("bounce_no_jump", air_cnt[0], 0);
    press(6);
    repeat (120) @(negedge clk);
    cap = 0;
    chk("bounce_one_land", land_cnt[0], 1);
    chk("bounce_air_cycles", air_cnt[0], 96);

    // Held button: one jump only.
    cap_begin();
    press(200);
    repeat (30) @(negedge clk);
    cap = 0;
    chk("held_one_land", land_cnt[0], 1);
    chk("held_air_cycles", air_cnt[0], 96);

    // Double jump near offset 12 in FALL, then an ignored third press.
    cap_begin();
    press(6);
    wait_off(1, 24, 200, "dbl_wait_apex");
    wait_off(1, 14, 200, "dbl_wait_fall");
    press(6);
    repeat (8) @(negedge clk);
    press(6);
    repeat (150) @(negedge clk);
    cap = 0;
    check_seq_a("nodbl");
    chk("nodbl_air_cycles", air_cnt[0], 96);
    chk("dbl_max", max_off[1], 24);
    chk("dbl_air_cycles", air_cnt[1], 154);
    chk("dbl_one_land", land_cnt[1], 1);

    // Press honoured on the landing edge.
    cap_begin();
    press(6);
    wait_edge(n + 10, 20, "coin_start");
    wait_edge(s[0] + len[0] * STEP - 6, 200, "coin_align");
    press(6);
    repeat (130) @(negedge clk);
    cap = 0;
    chk("coin_land_to_rise", gap, 1);
    chk("coin_two_lands", land_cnt[0], 2);

    // Reset mid-jump at offset 15.
    press(6);
    wait_off(0, 15, 100, "rst15_wait");
    rst = 1'b1;
    @(negedge clk);
    chk("rst15_offset", {27'b0, off_a}, 0);
    chk("rst15_airborne", {31'b0, air_a}, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst15_ground", {31'b0, air_a}, 0);

    // Saturation at 31 with RISE_STEP 7.
    cap_begin();
    press(6);
    repeat (130) @(negedge clk);
    cap = 0;
    chk("sat_max", max_off[2], 31);
    chk("sat_air_cycles", air_cnt[2], 100);
    chk("sat_one_land", land_cnt[2], 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
